// File: rtl/step_sequencer.sv
// Pattern-driven step sequencer: fires one step every tick_period cycles and
// gates each sample-player voice for gate_len cycles per hit, with retrigger.
//
// state | meaning
// IDLE  | stopped; all outputs held at 0, pattern writes still accepted
// RUN   | stepping through the pattern, gating voices on hits

module step_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_STEPS  = 16,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [23:0]           tick_period,
  input  logic [15:0]           gate_len,
  input  logic                  pat_we,
  input  logic [SW-1:0]         pat_addr,
  input  logic [NUM_VOICES-1:0] pat_wdata,
  output logic [NUM_VOICES-1:0] voice_en,
  output logic [SW-1:0]         step_idx,
  output logic                  step_pulse,
  output logic                  running
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           step_idx_q, step_idx_d;
  logic                    step_pulse_q, step_pulse_d;
  logic                    running_q, running_d;
  logic [23:0]             tick_q, tick_d;
  logic [NUM_VOICES-1:0]   voice_q, voice_d;
  logic [NUM_VOICES-1:0]   pend_q, pend_d;
  logic [15:0]             gate_q [NUM_VOICES];
  logic [15:0]             gate_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   pat_q  [NUM_STEPS];

  logic [NUM_VOICES-1:0]   row;
  logic [23:0]             p_eff;
  logic [23:0]             rem;

  assign row   = pat_q[step_idx_q];
  assign p_eff = (tick_period == 24'd0) ? 24'd1 : tick_period;
  // Cycles left until the next fire; a fire cycle reloads from the live period.
  assign rem   = step_pulse_q ? p_eff : tick_q;

  always_comb begin
    state_d      = state_q;
    step_idx_d   = step_idx_q;
    step_pulse_d = 1'b0;
    tick_d       = tick_q;
    voice_d      = voice_q;
    pend_d       = pend_q;
    gate_d       = gate_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d      = RUN;
          step_pulse_d = 1'b1;
          step_idx_d   = '0;
          tick_d       = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d    = IDLE;
          step_idx_d = '0;
          tick_d     = '0;
          voice_d    = '0;
          pend_d     = '0;
          for (int v = 0; v < NUM_VOICES; v++) gate_d[v] = '0;
        end else begin
          tick_d = rem - 24'd1;
          if (rem == 24'd1) begin
            step_pulse_d = 1'b1;
            step_idx_d   = (step_idx_q == SW'(NUM_STEPS - 1)) ? '0 : step_idx_q + SW'(1);
          end
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (step_pulse_q && row[v]) begin
              // A hit on a voice already playing inserts a one-cycle low gap.
              if (gate_len == 16'd0) begin
                voice_d[v] = 1'b0;
                pend_d[v]  = 1'b0;
                gate_d[v]  = '0;
              end else begin
                voice_d[v] = !voice_q[v];
                pend_d[v]  = voice_q[v];
                gate_d[v]  = gate_len - 16'd1;
              end
            end else if (pend_q[v]) begin
              voice_d[v] = 1'b1;
              pend_d[v]  = 1'b0;
            end else if (voice_q[v]) begin
              if (gate_q[v] == 16'd0) voice_d[v] = 1'b0;
              else                    gate_d[v]  = gate_q[v] - 16'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign running_d = (state_d == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b0;
      running_q    <= 1'b0;
      tick_q       <= '0;
      voice_q      <= '0;
      pend_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) gate_q[v] <= '0;
      for (int i = 0; i < NUM_STEPS; i++) pat_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      step_idx_q   <= step_idx_d;
      step_pulse_q <= step_pulse_d;
      running_q    <= running_d;
      tick_q       <= tick_d;
      voice_q      <= voice_d;
      pend_q       <= pend_d;
      for (int v = 0; v < NUM_VOICES; v++) gate_q[v] <= gate_d[v];
      for (int i = 0; i < NUM_STEPS; i++) begin
        if (pat_we && pat_addr == SW'(i)) pat_q[i] <= pat_wdata;
      end
    end
  end

  assign voice_en   = voice_q;
  assign step_idx   = step_idx_q;
  assign step_pulse = step_pulse_q;
  assign running    = running_q;

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of sample-player voices driven.
REQ-002 SHALL have parameter NUM_STEPS, default 16, pattern length; step index width SW = clog2(NUM_STEPS).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  run request, sampled each cycle.
REQ-006 SHALL have port stop  input  1  halt request, sampled each cycle.
REQ-007 SHALL have port tick_period  input  24  cycles per step; 0 treated as 1.
REQ-008 SHALL have port gate_len  input  16  cycles each voice enable stays high per hit.
REQ-009 SHALL have port pat_we  input  1  pattern write strobe.
REQ-010 SHALL have port pat_addr  input  SW  pattern step written.
REQ-011 SHALL have port pat_wdata  input  NUM_VOICES  voice-hit bits for that step.
REQ-012 SHALL have port voice_en  output  NUM_VOICES  enable to each sample player; registered.
REQ-013 SHALL have port step_idx  output  SW  current step; registered.
REQ-014 SHALL have port step_pulse  output  1  one-cycle strobe marking a step fire; registered.
REQ-015 SHALL have port running  output  1  high in RUN state; registered.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; running = (state == RUN).
REQ-017 SHALL, in IDLE with start=1 and stop=0 at cycle S, enter RUN and assert step_pulse=1, step_idx=0 at S+1 (cycle S+1 is fire cycle F0).
REQ-018 SHALL ignore start while in RUN; stop SHALL win when start and stop are both high.
REQ-019 SHALL latch tick_period (P, 0->1) at every fire cycle; next fire occurs exactly P cycles later.
REQ-020 SHALL advance step_idx by 1 on each fire after F0, wrapping NUM_STEPS-1 -> 0; step_pulse low on all non-fire cycles.
REQ-021 SHALL hold pattern in NUM_STEPS x NUM_VOICES flops; pat_we writes pat_wdata to pat_addr at any state.
REQ-022 SHALL read pattern row for step_idx in the fire cycle; a write to that row in the same cycle is not seen until the next visit (old data used).
REQ-023 SHALL, for a hit voice v at fire F with voice_en[v]=0 at F, drive voice_en[v]=1 for cycles F+1 .. F+gate_len.
REQ-024 SHALL, for a hit voice v at fire F with voice_en[v]=1 at F (retrigger), drive voice_en[v]=0 at F+1 and 1 for F+2 .. F+1+gate_len, so the player restarts from sample 0.
REQ-025 SHALL leave non-hit voices unaffected by a fire; their gates continue counting down.
REQ-026 SHALL latch gate_len per voice at its hit; gate_len=0 SHALL produce no assertion (and no retrigger gap).
REQ-027 SHALL, on stop=1 in RUN at cycle X, at X+1: state IDLE, running=0, voice_en=0, step_pulse=0, step_idx=0, gate and tick counters cleared; pattern retained.
REQ-028 SHALL hold all outputs at 0 in IDLE.

Reset
REQ-029 SHALL, while rst_n=0, immediately force state IDLE, voice_en=0, step_idx=0, step_pulse=0, running=0, all counters 0, pattern memory 0.
REQ-030 SHALL resume with start required after rst_n rises; reset mid-RUN abandons the pattern position and all gates.

Verification
REQ-031 Pattern step0=4'b0001, step1=4'b0010, P=10, gate_len=5, start pulse at S -> step_pulse at S+1, S+11, S+21; voice_en[0] high S+2..S+6; voice_en[1] high S+12..S+16.
REQ-032 Step0 and step1 both 4'b0001, P=4, gate_len=8 -> voice_en[0] high F0+1..F0+4, low F0+5, high F0+6..F0+13.
REQ-033 NUM_STEPS=16, P=1, all-zero pattern -> step_idx counts 0..15 then 0 on consecutive cycles; voice_en stays 0.
REQ-034 start and stop high same cycle in IDLE -> remains IDLE, running=0; stop during active gate -> voice_en=0 and step_idx=0 next cycle.
REQ-035 pat_we to current step_idx in its fire cycle with 4'b1111, prior data 4'b0000 -> no voice fires this pass; all four fire on next visit.
REQ-036 rst_n low mid-RUN with voices high -> all outputs 0 asynchronously; pattern reads back 0 (no hits) after restart.
